uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr_picker.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: widths, FSM state codes
// and the owner-index width helper.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W = 8;
  localparam int BIC_W  = 4;
  localparam logic [BIC_W-1:0] LAST_BIC_DEFAULT = 4'd9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_SEND = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  function automatic int owner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping around past the top requester.
module rr_picker #(
  parameter int NREQ    = 2,
  parameter int OWNER_W = 1
) (
  input  logic [NREQ-1:0]    req,
  input  logic [OWNER_W-1:0] ptr,
  output logic               valid,
  output logic [OWNER_W-1:0] winner
);

  localparam logic [OWNER_W:0] NREQ_V = (OWNER_W+1)'(NREQ);

  logic [2*NREQ-1:0]  dbl;
  logic [NREQ-1:0]    rot;
  logic [OWNER_W-1:0] off;
  logic [OWNER_W:0]   sum;

  always_comb begin
    dbl = {req, req};
    // rot[k] is the requester k places above the pointer
    rot = dbl[ptr +: NREQ];
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = OWNER_W'(k);
    end
    sum    = {1'b0, ptr} + {1'b0, off};
    winner = (sum >= NREQ_V) ? OWNER_W'(sum - NREQ_V) : sum[OWNER_W-1:0];
    valid  = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART serializer between NREQ byte requesters.
// Define UART_TX_ARBITER_TIMEOUT_EN to add the SEND-state watchdog (err).
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter logic [BIC_W-1:0] LAST_BIC = LAST_BIC_DEFAULT,
  parameter int GAP_CYCLES = 2,
`ifdef UART_TX_ARBITER_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 4096,
`endif
  localparam int OWNER_W = owner_width(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic [OWNER_W-1:0]     owner,
  output logic                   busy,
  output logic                   tx_load,
  output logic                   tx_transmit,
  output logic [BYTE_W-1:0]      tx_data,
  input  logic [BIC_W-1:0]       tx_bic,
  output logic                   err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam state_t AFTER_SEND = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  state_t              state_reg;
  logic [OWNER_W-1:0]  ptr_reg;
  logic [OWNER_W-1:0]  owner_reg;
  logic [BYTE_W-1:0]   tx_data_reg;
  logic [NREQ-1:0]     done_reg;
  logic                seen_last_reg;
  logic [GAP_W-1:0]    gap_cnt_reg;

  logic                pick_valid;
  logic [OWNER_W-1:0]  pick_idx;
  logic [OWNER_W-1:0]  ptr_next;
  logic                complete;
  logic                expire;

  rr_picker #(
    .NREQ    (NREQ),
    .OWNER_W (OWNER_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_reg),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  assign ptr_next = (owner_reg == OWNER_W'(NREQ - 1)) ? '0 : owner_reg + 1'b1;
  // seen_last only counts LAST_BIC observed inside SEND, so a stale count is harmless
  assign complete = (state_reg == ST_SEND) && seen_last_reg && (tx_bic != LAST_BIC);

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_reg;
  logic            err_reg;

  assign expire = (state_reg == ST_SEND) && !complete &&
                  (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      err_reg    <= expire;
      to_cnt_reg <= (state_reg == ST_SEND) ? to_cnt_reg + 1'b1 : '0;
    end
  end

  assign err = err_reg;
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      owner_reg     <= '0;
      tx_data_reg   <= '0;
      done_reg      <= '0;
      seen_last_reg <= 1'b0;
      gap_cnt_reg   <= '0;
    end else begin
      done_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_reg   <= pick_idx;
            tx_data_reg <= req_data[BYTE_W*pick_idx +: BYTE_W];
            state_reg   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          seen_last_reg <= 1'b0;
          state_reg     <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_bic == LAST_BIC) seen_last_reg <= 1'b1;
          if (complete) begin
            done_reg[owner_reg] <= 1'b1;
            ptr_reg             <= ptr_next;
            gap_cnt_reg         <= '0;
            state_reg           <= AFTER_SEND;
          end else if (expire) begin
            ptr_reg     <= ptr_next;
            gap_cnt_reg <= '0;
            state_reg   <= AFTER_SEND;
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) state_reg <= ST_IDLE;
          else gap_cnt_reg <= gap_cnt_reg + 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_grant
      assign grant[gi] = (state_reg == ST_LOAD) && (owner_reg == OWNER_W'(gi));
    end
  endgenerate

  assign done        = done_reg;
  assign owner       = owner_reg;
  assign tx_data     = tx_data_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign tx_load     = (state_reg == ST_LOAD);
  assign tx_transmit = (state_reg == ST_SEND);

endmodule
